tri_source_arbiter: RTL and testbench
=====================================

Name: tri_source_arbiter

Overview:
- Sequences the 3-input 8-bit select mux (alpha/beta/gamma, sel/cs) between three independent requesters.
- Round-robin arbiter with per-owner burst hold limit; drives the mux sel/cs lines and registers the selected byte into a one-entry valid/ready output stage.
- Sits between the three producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each source and of out_data.
- MAX_HOLD, 4, max consecutive beats one owner may take while another requester waits; range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- nreset  input  1  asynchronous active-low reset.
- req  input  3  request per source; bit0 alpha, bit1 beta, bit2 gamma; held with data until granted.
- alpha  input  WIDTH  source 0 data.
- beta  input  WIDTH  source 1 data.
- gamma  input  WIDTH  source 2 data.
- gnt  output  3  one-hot grant; combinational; high in the cycle the source's beat is captured.
- sel  output  2  mux select to datapath: 0/1/2 = chosen source, 3 when idle.
- cs  output  1  mux chip select; 1 (mux output forced 0) when no capture this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered beat.
- out_src  output  2  source index of out_data.
- out_ready  input  1  downstream accepts beat when out_valid & out_ready.

Behaviour:
- Reset (nreset low, async): out_valid=0, out_data=0, out_src=0, owner invalid, last=2 (alpha has first priority), hold_cnt=0. Combinational outputs during reset: gnt=0, sel=3, cs=1.
- can_load = !out_valid | out_ready. Capture occurs when can_load and req!=0.
- Arbitration, combinational, each cycle:
  - If an owner is valid, req[owner]=1, and not (hold_cnt==MAX_HOLD and another req bit set): choose the owner.
  - Otherwise choose the first set req bit scanning last+1, last+2, last+3 (mod 3).
- On capture, same cycle: gnt[choice]=1, sel=choice, cs=0. Next edge: out_data <= mux output, out_src <= choice, out_valid <= 1.
- On capture, ownership update:
  - If choice==owner: hold_cnt++.
  - Otherwise: owner <= choice, hold_cnt <= 1.
  - last <= choice.
- No capture: gnt=0, sel=3, cs=1.
  - out_valid & out_ready: out_valid <= 0, out_data/out_src hold.
  - out_valid & !out_ready: all registers hold (stall); requesters keep waiting.
- Owner release: the owner is cleared (invalid, hold_cnt=0) in any cycle with req[owner]=0 and no capture of the owner. hold_cnt saturates at MAX_HOLD.
- Lone requester: if the owner is the only requester, it continues past MAX_HOLD without limit. In that case hold_cnt stays at MAX_HOLD, so rotation happens as soon as another requester appears.
- Throughput: one beat per cycle while out_ready=1. Latency: req to out_valid = 1 cycle.
- Simultaneous stall + new req: no grant; the request is served on the first cycle out_ready=1, with gnt asserted in that same cycle.
- Reset mid-transfer: the in-flight beat is discarded (out_valid->0); arbitration restarts with alpha first priority.
- sel never takes 3 while cs=0; gnt is one-hot or zero.

Optional Feature:
- Macro: TRI_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While lock=1 and the owner is valid and requesting, the MAX_HOLD limit is ignored and the owner keeps every capture.
  - lock is ignored when no owner is valid.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- Reset then req=3'b111, out_ready=1, alpha=0x11, beta=0x22, gamma=0x33 held constant -> out_src sequence 0,0,0,0,1,1,1,1,2,2,2,2,0,... (MAX_HOLD=4); out_data follows 0x11/0x22/0x33; gnt one-hot every cycle.
- req=3'b010 only, out_ready=1 for 10 cycles -> beta captured every cycle, 10 beats of 0x22, no rotation, cs=0, sel=1 throughout.
- req=3'b001, out_ready=0 for 3 cycles after the first capture -> out_valid=1, out_data=0x11 held; gnt=0, cs=1, sel=3 during the stall; exactly one beat delivered when out_ready returns.
- Idle with req=0 -> sel=3, cs=1, gnt=0, out_valid drops after the last beat is accepted.
- nreset asserted while out_valid=1 and beta owns -> out_valid=0 immediately. After release with req=3'b110, gamma is not chosen first: beta (bit1) is granted first, because the scan starts from alpha.
- With TRI_ARB_LOCK_EN, lock=1, req=3'b011, alpha owner -> alpha granted for 8 consecutive beats. Drop lock -> beta granted on the next capture.

Source files
------------

// File: rtl/tri_source_arbiter.sv
// tri_source_arbiter
//   Round-robin arbiter that sequences a 3-input select mux (alpha/beta/gamma)
//   between three independent requesters. The current owner may keep the mux
//   for up to MAX_HOLD consecutive beats while someone else waits. Granted
//   beats go into a one-entry valid/ready output register.
//
//   Optional build macro: TRI_ARB_LOCK_EN adds a 'lock' input. While lock=1
//   and a valid owner is requesting, the owner keeps every capture and
//   MAX_HOLD is ignored.
//
// Ports:
//   clk        rising-edge clock
//   nreset     asynchronous active-low reset
//   req[2:0]   per-source request (bit0 alpha, bit1 beta, bit2 gamma)
//   alpha/beta/gamma  source data, held with req until granted
//   lock       (TRI_ARB_LOCK_EN only) pin ownership past MAX_HOLD
//   gnt[2:0]   one-hot grant, combinational, high in the capture cycle
//   sel[1:0]   mux select: 0/1/2 = source, 3 = idle
//   cs         mux chip select; 1 forces mux output to 0 (no capture)
//   out_valid/out_data/out_src  registered beat and its source index
//   out_ready  downstream accepts the beat when out_valid & out_ready
module tri_source_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] alpha,
  input  logic [WIDTH-1:0] beta,
  input  logic [WIDTH-1:0] gamma,
`ifdef TRI_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [2:0]       gnt,
  output logic [1:0]       sel,
  output logic             cs,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  logic [1:0]       owner;
  logic             owner_valid;
  logic [1:0]       last;
  logic [3:0]       hold_cnt;

  logic [2:0]       others;
  logic             limit_hit;
  logic             keep_owner;
  logic             found;
  logic [1:0]       cand;
  logic [1:0]       choice;
  logic             can_load;
  logic             capture;
  logic [WIDTH-1:0] mux_out;

  // Next index in the fixed ring 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the scan loop can leave one unassigned and infer a latch.
  always_comb begin
    others     = req & ~(3'b001 << owner);
    limit_hit  = (hold_cnt == MAX_HOLD_C) && (others != 3'b000);
`ifdef TRI_ARB_LOCK_EN
    if (lock) limit_hit = 1'b0;
`endif
    keep_owner = owner_valid && req[owner] && !limit_hit;

    // Scan last+1, last+2, last+3 and take the first requester found.
    choice = last;
    found  = 1'b0;
    cand   = last;
    for (int i = 0; i < 3; i++) begin
      cand = rr_next(cand);
      if (!found && req[cand]) begin
        choice = cand;
        found  = 1'b1;
      end
    end
    if (keep_owner) choice = owner;

    // Gate with nreset so the mux reads idle while reset is held.
    can_load = !out_valid || out_ready;
    capture  = nreset && can_load && (req != 3'b000);

    gnt = 3'b000;
    sel = 2'd3;
    cs  = 1'b1;
    if (capture) begin
      gnt = 3'b001 << choice;
      sel = choice;
      cs  = 1'b0;
    end

    // Model of the datapath mux: output forced to zero when deselected.
    mux_out = '0;
    if (!cs) begin
      case (sel)
        2'd0:    mux_out = alpha;
        2'd1:    mux_out = beta;
        2'd2:    mux_out = gamma;
        default: mux_out = '0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      // NOTE: every register, including the output data, has a defined
      // reset value; an in-flight beat is dropped and alpha gets priority.
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_src     <= 2'd0;
      owner       <= 2'd0;
      owner_valid <= 1'b0;
      last        <= 2'd2;
      hold_cnt    <= 4'd0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
      out_src   <= choice;
      last      <= choice;
      if (owner_valid && (choice == owner)) begin
        // Saturate so a lone requester runs on but rotates immediately
        // once anyone else shows up.
        if (hold_cnt != MAX_HOLD_C) hold_cnt <= hold_cnt + 4'd1;
      end else begin
        owner       <= choice;
        owner_valid <= 1'b1;
        hold_cnt    <= 4'd1;
      end
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // Owner gives up the mux as soon as it stops requesting.
      if (owner_valid && !req[owner]) begin
        owner       <= 2'd0;
        owner_valid <= 1'b0;
        hold_cnt    <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_tri_source_arbiter.sv
// Self-checking bench for tri_source_arbiter: directed scenarios followed by
// randomized requesters and back-pressure, all compared against a
// behavioural model of the arbitration rules.
module tb_tri_source_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             nreset;
  logic [2:0]       req_v;
  logic [WIDTH-1:0] alpha_v, beta_v, gamma_v;
  logic             lock_v;
  logic             out_ready_v;
  logic [2:0]       gnt;
  logic [1:0]       sel;
  logic             cs;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int             m_owner;   // -1 when no owner
  int             m_cnt;
  int             m_last;
  bit             m_ov;
  logic [WIDTH-1:0] m_od;
  int             m_os;

  tri_source_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .req       (req_v),
    .alpha     (alpha_v),
    .beta      (beta_v),
    .gamma     (gamma_v),
`ifdef TRI_ARB_LOCK_EN
    .lock      (lock_v),
`endif
    .gnt       (gnt),
    .sel       (sel),
    .cs        (cs),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = 2;
    m_ov    = 1'b0;
    m_od    = '0;
    m_os    = 0;
  endtask

  function automatic logic [WIDTH-1:0] src_data(input int s);
    case (s)
      0:       return alpha_v;
      1:       return beta_v;
      default: return gamma_v;
    endcase
  endfunction

  // Called just after a falling edge with inputs already applied. Checks the
  // combinational outputs, lets one rising edge pass, advances the model and
  // checks the registered outputs. ch returns the captured source or -1.
  task automatic step(output int ch);
    bit cap;
    bit others;
    bit lk;
    ch = -1;
    #1;
    lk  = 1'b0;
`ifdef TRI_ARB_LOCK_EN
    lk  = lock_v;
`endif
    cap = nreset && (!m_ov || out_ready_v) && (req_v != 3'b000);
    if (cap) begin
      others = 1'b0;
      for (int s = 0; s < 3; s++)
        if (s != m_owner && req_v[s]) others = 1'b1;
      if (m_owner >= 0 && req_v[m_owner] && (lk || !(m_cnt >= MAX_HOLD && others)))
        ch = m_owner;
      else
        for (int k = 1; k <= 3; k++)
          if (ch < 0 && req_v[(m_last + k) % 3]) ch = (m_last + k) % 3;
    end
    check("gnt", gnt, cap ? (32'd1 << ch) : 32'd0);
    check("sel", sel, cap ? ch : 3);
    check("cs",  cs,  cap ? 0 : 1);

    @(posedge clk);
    if (cap) begin
      m_od   = src_data(ch);
      m_os   = ch;
      m_ov   = 1'b1;
      m_last = ch;
      if (ch == m_owner) begin
        if (m_cnt < MAX_HOLD) m_cnt++;
      end else begin
        m_owner = ch;
        m_cnt   = 1;
      end
    end else begin
      if (m_ov && out_ready_v) m_ov = 1'b0;
      if (m_owner >= 0 && !req_v[m_owner]) begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end

    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    check("out_data",  out_data,  m_od);
    check("out_src",   out_src,   m_os);
  endtask

  int ch;
  int rr_exp [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
  bit             r_req  [3];
  logic [WIDTH-1:0] r_data [3];

  initial begin
    model_reset();
    nreset      = 1'b0;
    req_v       = 3'b111;
    alpha_v     = 8'h11;
    beta_v      = 8'h22;
    gamma_v     = 8'h33;
    lock_v      = 1'b0;
    out_ready_v = 1'b1;

    // Reset state, with requests present to show the outputs stay idle.
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_src",   out_src,   0);
    check("rst_gnt",       gnt,       0);
    check("rst_sel",       sel,       3);
    check("rst_cs",        cs,        1);
    nreset = 1'b1;

    // All three requesting: four beats each, starting at alpha.
    for (int i = 0; i < 13; i++) begin
      step(ch);
      check("rr_seq", ch, rr_exp[i]);
    end

    // Lone beta: captured every cycle, never rotated away.
    req_v = 3'b010;
    for (int i = 0; i < 10; i++) begin
      step(ch);
      check("lone_beta", ch, 1);
      check("lone_data", out_data, 8'h22);
    end

    // Reset while beta owns and a beat is in flight.
    out_ready_v = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_gnt",   gnt,       0);
    check("midrst_sel",   sel,       3);
    check("midrst_cs",    cs,        1);
    model_reset();
    @(negedge clk);
    nreset      = 1'b1;
    out_ready_v = 1'b1;
    req_v       = 3'b110;
    step(ch);
    check("after_rst_first", ch, 1);

    // Alpha alone, then a 3-cycle stall with alpha still requesting.
    req_v = 3'b001;
    step(ch);
    check("stall_first", ch, 0);
    out_ready_v = 1'b0;
    repeat (3) begin
      step(ch);
      check("stall_no_cap", ch, -1);
      check("stall_data", out_data, 8'h11);
    end
    out_ready_v = 1'b1;
    step(ch);
    check("stall_release", ch, 0);

    // Idle: last beat drains, mux idles.
    req_v = 3'b000;
    repeat (3) step(ch);
    check("idle_valid", out_valid, 0);

`ifdef TRI_ARB_LOCK_EN
    // Locked alpha keeps the mux well past MAX_HOLD, then yields.
    nreset = 1'b0;
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
    lock_v = 1'b1;
    req_v  = 3'b011;
    for (int i = 0; i < 8; i++) begin
      step(ch);
      check("lock_alpha", ch, 0);
    end
    lock_v = 1'b0;
    step(ch);
    check("unlock_beta", ch, 1);
`endif

    // Randomized requesters (data held until granted) and back-pressure.
    for (int s = 0; s < 3; s++) begin
      r_req[s]  = 1'b0;
      r_data[s] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      out_ready_v = ($urandom_range(0, 3) != 0);
`ifdef TRI_ARB_LOCK_EN
      lock_v = ($urandom_range(0, 7) == 0);
`endif
      req_v   = {r_req[2], r_req[1], r_req[0]};
      alpha_v = r_data[0];
      beta_v  = r_data[1];
      gamma_v = r_data[2];
      step(ch);
      for (int s = 0; s < 3; s++) begin
        if (ch == s) begin
          r_req[s]  = ($urandom_range(0, 3) != 0);
          r_data[s] = 8'($urandom);
        end else if (!r_req[s]) begin
          r_req[s] = ($urandom_range(0, 2) == 0);
          if (r_req[s]) r_data[s] = 8'($urandom);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
